// File: rtl/kyber_pkg.sv
// kyber_pkg: shared constants, FSM state type and the basemul twiddle (gamma) table.
package kyber_pkg;
    localparam int Q = 3329;
    localparam int N = 256;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // gamma[k] = 17^(2*BitRev7(k)+1) mod Q, built at elaboration by square-and-multiply
    function automatic logic [127:0][11:0] gen_gamma();
        logic [127:0][11:0] t;
        int e, b, r;
        for (int k = 0; k < 128; k++) begin
            e = 0;
            for (int i = 0; i < 7; i++) e = e | (((k >> i) & 1) << (6 - i));
            e = 2 * e + 1;
            b = 17;
            r = 1;
            while (e > 0) begin
                if ((e & 1) != 0) r = (r * b) % Q;
                b = (b * b) % Q;
                e = e >> 1;
            end
            t[k] = 12'(r);
        end
        return t;
    endfunction

    localparam logic [127:0][11:0] GAMMA = gen_gamma();

    function automatic logic [11:0] norm_q(input logic signed [15:0] v);
        return v[15] ? 12'(v + 16'(Q)) : 12'(v);
    endfunction
endpackage

// File: rtl/basemul_ntt_if.sv
// basemul_ntt_if: start/done handshake plus operand and result coefficient arrays.
interface basemul_ntt_if #(parameter int N = 256);
    logic start;
    logic done;
    logic signed [15:0] f_hat [N];
    logic signed [15:0] g_hat [N];
    logic signed [15:0] h_hat [N];

    modport master(output start, f_hat, g_hat, input h_hat, done);
    modport slave(input start, f_hat, g_hat, output h_hat, done);
endinterface

// File: rtl/mod_q_reduce.sv
// mod_q_reduce: combinational exact reduction of x < 2^26 into [0,Q) (Barrett, one correction).
module mod_q_reduce #(
    parameter int Q = 3329
) (
    input  logic [25:0] x,
    output logic [11:0] r
);
    localparam logic [26:0] M = 27'((64'd1 << 38) / Q);
    localparam logic [25:0] QW = 26'(Q);

    logic [14:0] q;
    logic [25:0] d;

    // quotient estimate is never high and at most one low, so d < 2Q
    assign q = 15'(({27'd0, x} * M) >> 38);
    assign d = x - {11'd0, q} * QW;
    assign r = 12'(d >= QW ? d - QW : d);
endmodule

// File: rtl/basemul_ntt.sv
// basemul_ntt: NTT-domain pointwise multiply, one coefficient pair per cycle, two-stage pipeline.
// Define BASEMUL_INPUT_REG_EN to capture f_hat/g_hat when start is accepted.
module basemul_ntt #(
    parameter int N = kyber_pkg::N,
    parameter int Q = kyber_pkg::Q
) (
    input logic    clk,
    input logic    rst_n,
    basemul_ntt_if.slave bus
);
    import kyber_pkg::*;

    localparam int KW = $clog2(N) - 1;

    state_t state;
    logic [KW-1:0] k, k1;
    logic [1:0] cnt;
    logic v1, done;
    logic [23:0] p00, p11, p01, p10;
    logic signed [15:0] h [N];
    logic signed [15:0] f0, f1, g0, g1;
    logic [11:0] a0, a1, b0, b1, r11, r0, r1, gk;
    logic [23:0] m11;

`ifdef BASEMUL_INPUT_REG_EN
    logic signed [15:0] f_r [N];
    logic signed [15:0] g_r [N];
    logic accept;

    assign accept = bus.start && (state == IDLE || state == DONE);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            f_r <= '{default: '0};
            g_r <= '{default: '0};
        end else if (accept) begin
            f_r <= bus.f_hat;
            g_r <= bus.g_hat;
        end

    assign f0 = f_r[{k, 1'b0}];
    assign f1 = f_r[{k, 1'b1}];
    assign g0 = g_r[{k, 1'b0}];
    assign g1 = g_r[{k, 1'b1}];
`else
    assign f0 = bus.f_hat[{k, 1'b0}];
    assign f1 = bus.f_hat[{k, 1'b1}];
    assign g0 = bus.g_hat[{k, 1'b0}];
    assign g1 = bus.g_hat[{k, 1'b1}];
`endif

    assign a0 = norm_q(f0);
    assign a1 = norm_q(f1);
    assign b0 = norm_q(g0);
    assign b1 = norm_q(g1);

    assign gk  = GAMMA[k1];
    assign m11 = r11 * gk;

    mod_q_reduce #(.Q(Q)) u_r11 (.x({2'b0, p11}), .r(r11));
    mod_q_reduce #(.Q(Q)) u_r0  (.x({2'b0, p00} + {2'b0, m11}), .r(r0));
    mod_q_reduce #(.Q(Q)) u_r1  (.x({2'b0, p01} + {2'b0, p10}), .r(r1));

    assign bus.h_hat = h;
    assign bus.done  = done;

    // DRAIN covers the final write plus two settling cycles, giving done 131 edges after start
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            k1    <= '0;
            cnt   <= '0;
            v1    <= 1'b0;
            p00   <= '0;
            p11   <= '0;
            p01   <= '0;
            p10   <= '0;
            h     <= '{default: '0};
            done  <= 1'b0;
        end else begin
            v1 <= state == RUN;
            k1 <= k;
            if (state == RUN) begin
                p00 <= a0 * b0;
                p11 <= a1 * b1;
                p01 <= a0 * b1;
                p10 <= a1 * b0;
            end
            if (v1) begin
                h[{k1, 1'b0}] <= 16'(r0);
                h[{k1, 1'b1}] <= 16'(r1);
            end
            case (state)
                IDLE, DONE: if (bus.start) begin
                    state <= RUN;
                    k     <= '0;
                    done  <= 1'b0;
                end
                RUN: begin
                    k <= k + 1'b1;
                    if (&k) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == 2'd2) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule
